alu_seq_scheduler: RTL
======================

# alu_seq_scheduler

Two-requester scheduler and sequencer for the 4-bit sequential ALU (nibble-serial: op1, op2, opcode, execute). It arbitrates round-robin between two clients and latches the winner's operand word. It drives the ALU's enable/data nibble stream for the four load/execute cycles, checks the ALU done flag, and returns result and flags to the winning client. It sits between client logic and the ALU, which shares `clk`; the ALU's own reset is driven by this block.

## Interface
- `TIMEOUT`, default 8: cycles spent in WAIT without the done flag before the watchdog fires. Used only with `ALU_SCHED_WATCHDOG_EN`. Legal range 1..255.
- `clk  in  1`: clock; the ALU is clocked by the same net.
- `reset  in  1`: synchronous, active-high.
- `req  in  2`: per-client request level; bit i belongs to client i.
- `req_word0  in  12`: client 0 transaction, {opcode[11:8], op2[7:4], op1[3:0]}.
- `req_word1  in  12`: client 1 transaction, same packing.
- `gnt  out  2`: one-hot acceptance; combinational from state and `req`.
- `rsp_valid  out  2`: one-hot, one-cycle response strobe; registered.
- `rsp_result  out  4`: ALU result, held until the next response.
- `rsp_flags  out  4`: {sign, zero, carry, done} from the ALU, held.
- `rsp_err  out  1`: response produced by a watchdog abort; held.
- `busy  out  1`: high in every state except IDLE.
- `alu_rst  out  1`: to ALU reset; equals `reset` OR (state == RECOVER).
- `alu_en  out  1`: to ALU enable.
- `alu_data  out  4`: to ALU data nibble.
- `alu_result  in  4`: from ALU result.
- `alu_flags  in  4`: from ALU flags {sign, zero, carry, done}.

## Operation
- **States:** IDLE, OP1, OP2, OPC, EXEC, WAIT, RECOVER.
- **IDLE**
  - `alu_en`=0, `alu_data`=0.
  - If any `req` bit is set, the winner's `gnt` bit is 1 in this cycle. At the clock edge the block latches the winner's word and winner index, then moves to OP1.
  - A client must hold `req` and its word stable until it sees `gnt`. A `req` still high in the cycle after `gnt` is a new transaction.
- **Arbitration:** round-robin through a 1-bit `last` pointer.
  - If only one client requests, it wins.
  - If both request, the client not equal to `last` wins.
  - `last` updates only on a grant. Reset value of `last` is 1, so client 0 wins the first tie.
- **Load and execute sequence:** `alu_en`=1 in all four states.
  - OP1: `alu_data`=op1.
  - OP2: `alu_data`=op2.
  - OPC: `alu_data`=opcode.
  - EXEC: `alu_data`=0.
  - Each state advances unconditionally.
- **Opcode handling:** the opcode is passed through uninterpreted. Undefined opcodes (0xB–0xF) still complete with done=1 and the ALU's previous result.
- **WAIT:** `alu_en`=0.
  - If `alu_flags[0]`=1: capture `alu_result` and `alu_flags`, clear `rsp_err`, pulse `rsp_valid[winner]` on the next cycle, return to IDLE.
  - Otherwise stay in WAIT (see Configuration).
- **RECOVER:** one cycle with `alu_rst`=1.
  - Registers `rsp_result`=0, `rsp_flags`=0, `rsp_err`=1 and pulses `rsp_valid[winner]`, all visible in the following IDLE cycle.
  - Returns to IDLE; the ALU is back at its first-operand state.
- **Reset values:** state=IDLE, `gnt`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0, `rsp_err`=0, `busy`=0, `alu_en`=0, `alu_data`=0, `alu_rst`=1, `last`=1, watchdog count=0.
- **Reset mid-transaction:** aborts the transaction with no response. The ALU is reset in the same edge, so both return to their initial states together.

## Timing
- Grant in cycle 0 (IDLE). ALU samples op1/op2/opcode/execute at the ends of cycles 1–4. WAIT is cycle 5 with done already 1. `rsp_valid` is high in cycle 6.
- Latency is 6 cycles grant-to-response.
- Cycle 6 is IDLE, so a new grant may coincide with `rsp_valid`. Sustained throughput is one operation per 6 cycles.
- `gnt` and `rsp_valid` are never both set for the same client in the same cycle unless that client re-requests. Both are allowed.
- A `req` arriving while `busy`=1 is ignored until IDLE; there is no queueing.

## Configuration
- `ALU_SCHED_WATCHDOG_EN` defined:
  - An 8-bit counter clears on entry to WAIT and increments in each WAIT cycle with done=0.
  - When it reaches `TIMEOUT`, the next state is RECOVER.
- Not defined:
  - WAIT holds indefinitely until done=1.
  - RECOVER is unreachable, `rsp_err` is constant 0, and `TIMEOUT` is unused.

## Test plan
- **Reset:** assert `reset` 2 cycles with `req`=11 → no `gnt`, `alu_rst`=1, all outputs 0. After release, client 0 is granted first.
- **SUM with carry:** client 0 word {0x0, 0x8, 0x9} → `alu_data` sequence 9, 8, 0, 0 with `alu_en`=1; `rsp_valid`=01 exactly 6 cycles after `gnt`; result 0x1, flags 0011.
- **SUB borrow:** client 1 word {0x1, 0x5, 0x3} → `rsp_valid`=10, result 0xE, flags 1001, `rsp_err`=0.
- **Tie:** both clients request continuously for 4 transactions → grant order 0, 1, 0, 1, with the next `gnt` in the same cycle as each `rsp_valid`.
- **Reset mid-operation:** reset asserted in OPC → no `rsp_valid`. A subsequent transaction (op1=0x3, op2=0x3, compare opcode 0xA) returns result 0x1, flags 0001.
- **Watchdog (macro on, `TIMEOUT`=3):** bench ALU model holds done=0 → 3 WAIT cycles, one RECOVER cycle with `alu_rst`=1, then `rsp_valid` with `rsp_err`=1, result 0, flags 0.

Source files
------------

// File: rtl/alu_seq_scheduler.sv
// alu_seq_scheduler: round-robin two-client front end and nibble-serial
// sequencer for the 4-bit sequential ALU (op1, op2, opcode, execute).
//
// Optional watchdog: define ALU_SCHED_WATCHDOG_EN to abort a WAIT that
// lasts TIMEOUT cycles without done (ALU reset via RECOVER, rsp_err=1).
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req[1:0]          : per-client request level
//   req_word0/1[11:0] : {opcode, op2, op1} per client
//   gnt[1:0]          : one-hot acceptance (combinational, IDLE only)
//   rsp_valid[1:0]    : one-cycle response strobe to the winner
//   rsp_result[3:0]   : held ALU result
//   rsp_flags[3:0]    : held {sign, zero, carry, done}
//   rsp_err           : held watchdog-abort indication
//   busy              : high outside IDLE
//   alu_rst           : ALU reset (reset or RECOVER)
//   alu_en, alu_data  : ALU enable and data nibble
//   alu_result, alu_flags : ALU outputs
module alu_seq_scheduler #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [11:0] req_word0,
    input  logic [11:0] req_word1,
    output logic [1:0]  gnt,
    output logic [1:0]  rsp_valid,
    output logic [3:0]  rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy,
    output logic        alu_rst,
    output logic        alu_en,
    output logic [3:0]  alu_data,
    input  logic [3:0]  alu_result,
    input  logic [3:0]  alu_flags
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP1,
        S_OP2,
        S_OPC,
        S_EXEC,
        S_WAIT,
        S_RECOVER
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("alu_seq_scheduler: TIMEOUT must be 1..255");
    end

    state_t      state;
    logic        last;
    logic        winner;
    logic [11:0] word_q;

    logic        win;
    logic [11:0] win_word;

`ifdef ALU_SCHED_WATCHDOG_EN
    logic [7:0]  wd_cnt;
`endif

    // On a tie the client that did not win last time gets the grant.
    always_comb begin
        win = 1'b0;
        unique case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
        win_word = win ? req_word1 : req_word0;
        gnt = 2'b00;
        if (!reset && state == S_IDLE && req != 2'b00)
            gnt = win ? 2'b10 : 2'b01;
    end

    assign busy    = (state != S_IDLE);
    assign alu_rst = reset | (state == S_RECOVER);

    // alu_en/alu_data are registered one state ahead so the nibble is
    // stable for the whole state the ALU samples it in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last       <= 1'b1;
            winner     <= 1'b0;
            word_q     <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            alu_en     <= 1'b0;
            alu_data   <= '0;
`ifdef ALU_SCHED_WATCHDOG_EN
            wd_cnt     <= '0;
`endif
        end else begin
            rsp_valid <= '0;
            unique case (state)
                S_IDLE: begin
                    alu_en   <= 1'b0;
                    alu_data <= '0;
                    if (req != 2'b00) begin
                        word_q   <= win_word;
                        winner   <= win;
                        last     <= win;
                        alu_en   <= 1'b1;
                        alu_data <= win_word[3:0];
                        state    <= S_OP1;
                    end
                end
                S_OP1: begin
                    alu_data <= word_q[7:4];
                    state    <= S_OP2;
                end
                S_OP2: begin
                    alu_data <= word_q[11:8];
                    state    <= S_OPC;
                end
                S_OPC: begin
                    alu_data <= '0;
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    alu_en   <= 1'b0;
                    alu_data <= '0;
                    state    <= S_WAIT;
`ifdef ALU_SCHED_WATCHDOG_EN
                    wd_cnt   <= '0;
`endif
                end
                S_WAIT: begin
                    if (alu_flags[0]) begin
                        rsp_result <= alu_result;
                        rsp_flags  <= alu_flags;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= winner ? 2'b10 : 2'b01;
                        state      <= S_IDLE;
                    end
`ifdef ALU_SCHED_WATCHDOG_EN
                    else begin
                        wd_cnt <= wd_cnt + 8'd1;
                        if (wd_cnt + 8'd1 == TIMEOUT[7:0])
                            state <= S_RECOVER;
                    end
`endif
                end
                S_RECOVER: begin
                    rsp_result <= '0;
                    rsp_flags  <= '0;
                    rsp_err    <= 1'b1;
                    rsp_valid  <= winner ? 2'b10 : 2'b01;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
